load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the single-cycle datapath's execute/ALU result and the word-organised data memory (byte address in, word-indexed storage, synchronous write, asynchronous read).
- Accepts one load/store request at a time over a valid/ready handshake. Performs alignment checking, byte-lane extraction with sign/zero extension, and sub-word stores via read-modify-write.
- Drives the data memory's we/addr/wd and consumes its rd.

Parameters:
WIDTH, 32, data and address width in bits; only 32 is supported.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
req_addr  in  WIDTH  byte address
req_wdata  in  WIDTH  store data (sub-word data in low bits)
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  WIDTH  extended load data; 0 for stores and faults
rsp_fault  out  1  misaligned or illegal funct3; valid with rsp_valid
mem_we  out  1  to data memory write enable
mem_addr  out  WIDTH  to data memory, byte address, bits [1:0] always 0
mem_wd  out  WIDTH  to data memory write data
mem_rd  in  WIDTH  from data memory, asynchronous read data

Behaviour:
- Reset (async, immediate):
  - state=IDLE; rsp_valid=0, rsp_rdata=0, rsp_fault=0, mem_we=0, mem_addr=0, mem_wd=0.
  - Reset mid-operation abandons the request; no write may occur on any edge while reset is high.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1. On an edge with req_valid=1, latch we, funct3, addr and wdata.
  - Fault check:
    - funct3 in {3,6,7} for loads or {3..7} for stores → fault.
    - Half-word with addr[0]=1 → fault.
    - Word with addr[1:0]≠0 → fault.
  - Next state: fault → RESP; load → READ; SW → WRITE; SB/SH → READ.
- READ:
  - mem_addr={addr[31:2],2'b00}, mem_we=0. At the edge, register mem_rd.
  - Load → compute rsp_rdata:
    - LB/LBU select lane addr[1:0]; LH/LHU select half addr[1].
    - Sign-extend for LB/LH, zero-extend for LBU/LHU.
    - Next state RESP.
  - SB/SH → next state WRITE.
- WRITE:
  - mem_we=1, same mem_addr.
  - mem_wd = wdata for SW. For SB/SH it is the registered read word with wdata[7:0] (SB) or wdata[15:0] (SH) merged into the addressed lane, other lanes unchanged.
  - Next state RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle, rsp_fault reflects the check, then IDLE.
  - rsp_rdata/rsp_fault hold their value until the next RESP.
- mem_we, mem_addr and mem_wd are decoded from state plus latched registers. Outside READ/WRITE: mem_we=0, mem_addr=0, mem_wd=0.
- Latency from the accepting edge to the rsp_valid cycle:
  - Fault: 1 cycle.
  - Load or SW: 2 cycles.
  - SB/SH: 3 cycles.
- Back-to-back: a new request is accepted no earlier than the edge ending RESP; req_valid while busy is ignored, and the requester holds it.
- Faulting requests never assert mem_we.
- Address wrap: addresses are not range-checked; the memory truncates.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
  - State enum lsu_state_t {IDLE, READ, WRITE, RESP}.
  - Fault-check function.
- One combinational sub-module, lsu_lane_align:
  - Inputs: funct3, addr[1:0], word, wdata.
  - Outputs: extended load data and merged store word.
- The FSM and registers stay in load_store_unit.

Test Plan:
1. Reset held 3 cycles with req_valid=1 → req_ready=0 during reset, mem_we never 1, rsp_valid=0; after release req_ready=1.
2. SW addr 0x10, wdata 0xDEADBEEF → mem_we=1 in the cycle after accept with mem_addr 0x10; rsp_valid 2 cycles after accept, rsp_fault=0. Then LW 0x10 → rsp_rdata 0xDEADBEEF at 2 cycles.
3. With word 0x10 = 0xDEADBEEF:
   - LB 0x13 → 0xFFFFFFDE.
   - LBU 0x13 → 0x000000DE.
   - LH 0x12 → 0xFFFFDEAD.
   - LHU 0x10 → 0x0000BEEF.
4. SB 0x11, wdata 0x12345677 → READ then WRITE with mem_wd 0xDEAD77EF, rsp at 3 cycles. SH 0x12, wdata 0xAAAA1234 → word becomes 0x123477EF.
5. Faults, each giving rsp_valid 1 cycle after accept, rsp_fault=1, rsp_rdata=0 and no mem_we:
   - LW 0x11.
   - SH 0x13.
   - Load funct3=3.
   - Store funct3=4.
6. Assert reset during WRITE of an SB → mem_we drops immediately, the word is unchanged on readback, and no rsp_valid occurs.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM state type and request legality check for the load/store unit.
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_t;
  function automatic logic lsu_fault(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic illegal, mis;
    illegal = we ? (f3 > F3_W) : (f3 == 3'd3 || f3 > F3_HU);
    mis = (f3 == F3_H || f3 == F3_HU) ? off[0] : (f3 == F3_W) ? |off : 1'b0;
    return illegal || mis;
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte/half lane extraction with sign/zero extension, and sub-word merge into a memory word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);
  logic [4:0]  bsh;
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] bmask, hmask;
  always_comb begin
    bsh = {off_i, 3'b000};
    b = 8'(word_i >> bsh);
    h = off_i[1] ? word_i[31:16] : word_i[15:0];
    bmask = 32'h0000_00FF << bsh;
    hmask = off_i[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
    load_o = funct3_i == F3_B  ? {{24{b[7]}}, b} :
             funct3_i == F3_BU ? {24'b0, b} :
             funct3_i == F3_H  ? {{16{h[15]}}, h} :
             funct3_i == F3_HU ? {16'b0, h} :
             funct3_i == F3_W  ? word_i : '0;
    // Replicating the store data across all lanes lets the mask pick the target lane.
    store_o = funct3_i == F3_B ? (word_i & ~bmask) | ({4{wdata_i[7:0]}} & bmask) :
              funct3_i == F3_H ? (word_i & ~hmask) | ({2{wdata_i[15:0]}} & hmask) : wdata_i;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-request load/store engine between the ALU result and a word-organised data memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_fault,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd
);
  lsu_state_t       state_q, state_d;
  logic             we_q, rflt_q, req_fault;
  logic [2:0]       f3_q;
  logic [WIDTH-1:0] addr_q, wdata_q, rd_q, rdata_q, ld, st, align_word;
  assign req_fault = lsu_fault(req_we, req_funct3, req_addr[1:0]);
  // Loads extend straight from memory in READ; merges use the word captured in READ.
  assign align_word = state_q == WRITE ? rd_q : mem_rd;
  lsu_lane_align u_align (
    .funct3_i(f3_q),
    .off_i   (addr_q[1:0]),
    .word_i  (align_word),
    .wdata_i (wdata_q),
    .load_o  (ld),
    .store_o (st)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q == IDLE  ? (req_valid ? (req_fault ? RESP :
                                  (req_we && req_funct3 == F3_W) ? WRITE : READ) : IDLE) :
              state_q == READ  ? (we_q ? WRITE : RESP) :
              state_q == WRITE ? RESP : IDLE;
  end
  always_comb begin
    req_ready = state_q == IDLE && !reset;
    rsp_valid = state_q == RESP;
    rsp_rdata = rdata_q;
    rsp_fault = rflt_q;
    mem_we    = state_q == WRITE;
    mem_addr  = (state_q == READ || state_q == WRITE) ? {addr_q[WIDTH-1:2], 2'b00} : '0;
    mem_wd    = state_q == WRITE ? st : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      rdata_q <= '0;
      rflt_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && req_valid) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        if (req_fault) begin
          rdata_q <= '0;
          rflt_q  <= 1'b1;
        end
      end
      if (state_q == READ) begin
        rd_q <= mem_rd;
        if (!we_q) begin
          rdata_q <= ld;
          rflt_q  <= 1'b0;
        end
      end
      if (state_q == WRITE) begin
        rdata_q <= '0;
        rflt_q  <= 1'b0;
      end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench with a byte-level memory model and randomized requests.
module tb_load_store_unit;
  typedef struct {logic [31:0] rdata; logic fault; int cyc;} rsp_t;
  typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;
  logic        clk = 0, reset = 1;
  logic        req_valid = 0, req_we = 0;
  logic [2:0]  req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        req_ready, rsp_valid, rsp_fault, mem_we;
  logic [31:0] rsp_rdata, mem_addr, mem_wd, mem_rd;
  logic [31:0] dmem [16];
  logic [31:0] ref_mem [16];
  rsp_t        sb [$];
  wr_t         wq [$];
  rsp_t        mr;
  wr_t         mw;
  int          cyc = 0, n_vec = 0, n_err = 0;
  bit          abort_mode = 0;

  load_store_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign mem_rd = dmem[mem_addr[5:2]];
  always @(posedge clk) if (mem_we) dmem[mem_addr[5:2]] <= mem_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: compares every write and every response against the scoreboard queues.
  always @(negedge clk) if (!reset) begin
    if (mem_we && !abort_mode) begin
      if (wq.size() == 0) fail("unexpected_write");
      else begin
        mw = wq.pop_front();
        chk("mem_addr", mem_addr, mw.addr);
        chk("mem_wd", mem_wd, mw.data);
      end
    end
    if (rsp_valid) begin
      if (abort_mode) fail("rsp_after_abort");
      else if (sb.size() == 0) fail("unexpected_rsp");
      else begin
        mr = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, mr.rdata);
        chk("rsp_fault", 32'(rsp_fault), 32'(mr.fault));
        chk("rsp_cycle", cyc, mr.cyc);
      end
    end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
      fail("rsp_timeout");
      void'(sb.pop_front());
    end
  end

  // Reference: memory as bytes; access size from funct3, extension by sign of the top loaded byte.
  task automatic issue(input bit we, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd);
    rsp_t r;
    bit [7:0] b [4];
    bit [31:0] val, word;
    int sz, n, off;
    bit legal;
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      fail("accept_timeout");
      req_valid = 0;
      return;
    end
    sz = f3[1:0] == 0 ? 1 : f3[1:0] == 1 ? 2 : 4;
    legal = we ? (f3 <= 2) : (f3 inside {0, 1, 2, 4, 5});
    off = a[1:0];
    word = ref_mem[a[5:2]];
    for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
    if (!legal || (off % sz) != 0) begin
      r.rdata = 0; r.fault = 1; r.cyc = cyc + 1;
    end else if (!we) begin
      val = 0;
      for (int i = 0; i < sz; i++) val = val | (32'(b[off+i]) << (8*i));
      if (!f3[2] && sz < 4 && val[8*sz-1]) val = val | (32'hFFFF_FFFF << (8*sz));
      r.rdata = val; r.fault = 0; r.cyc = cyc + 2;
    end else begin
      for (int i = 0; i < sz; i++) b[off+i] = wd[8*i +: 8];
      word = {b[3], b[2], b[1], b[0]};
      ref_mem[a[5:2]] = word;
      wq.push_back('{addr: {a[31:2], 2'b00}, data: word});
      r.rdata = 0; r.fault = 0; r.cyc = cyc + (sz == 4 ? 2 : 3);
    end
    sb.push_back(r);
    @(negedge clk);
  endtask

  task automatic drain();
    req_valid = 0;
    for (int i = 0; i < 20 && (sb.size() > 0 || wq.size() > 0); i++) @(negedge clk);
    if (sb.size() > 0 || wq.size() > 0) fail("drain_timeout");
    @(negedge clk);
  endtask

  initial begin
    bit we;
    bit [2:0] f3;
    bit [31:0] a;
    int n;
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      dmem[i] = a;
      ref_mem[i] = a;
    end
    req_valid = 1; req_we = 1; req_funct3 = 3'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_we", 32'(mem_we), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
    end
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_fault", 32'(rsp_fault), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wd", mem_wd, 0);
    req_valid = 0;
    reset = 0;
    #1 chk("post_rst_ready", 32'(req_ready), 1);
    issue(1, 3'd2, 32'h10, 32'hDEADBEEF);
    issue(0, 3'd2, 32'h10, 32'h0);
    issue(0, 3'd0, 32'h13, 32'h0);
    issue(0, 3'd4, 32'h13, 32'h0);
    issue(0, 3'd1, 32'h12, 32'h0);
    issue(0, 3'd5, 32'h10, 32'h0);
    issue(1, 3'd0, 32'h11, 32'h12345677);
    issue(0, 3'd2, 32'h10, 32'h0);
    issue(1, 3'd1, 32'h12, 32'hAAAA1234);
    issue(0, 3'd2, 32'h10, 32'h0);
    issue(0, 3'd2, 32'h11, 32'h0);
    issue(1, 3'd1, 32'h13, 32'h5555);
    issue(0, 3'd3, 32'h10, 32'h0);
    issue(1, 3'd4, 32'h10, 32'h1);
    issue(0, 3'd2, 32'h10, 32'h0);
    drain();
    abort_mode = 1;
    req_we = 1; req_funct3 = 3'd0; req_addr = 32'h21; req_wdata = 32'h5A; req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0;
    n = 0;
    while (!mem_we && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!mem_we) fail("abort_no_write");
    reset = 1;
    #1 chk("abort_we_drop", 32'(mem_we), 0);
    chk("abort_rsp_valid", 32'(rsp_valid), 0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_hold_we", 32'(mem_we), 0);
      chk("abort_hold_rsp", 32'(rsp_valid), 0);
    end
    reset = 0;
    abort_mode = 0;
    #1 chk("abort_ready", 32'(req_ready), 1);
    issue(0, 3'd2, 32'h20, 32'h0);
    drain();
    for (int k = 0; k < 250; k++) begin
      we = $urandom_range(0, 1);
      if ($urandom_range(0, 7) < 6) f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 3) == 3 ? 5 : $urandom_range(0, 2) + ($urandom_range(0, 1) ? 0 : 0));
      else f3 = 3'($urandom_range(0, 7));
      if (!we && $urandom_range(0, 4) == 0) f3 = 3'd4;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = f3[1:0] == 1 ? {a[31:1], 1'b0} : f3[1:0] == 2 ? {a[31:2], 2'b00} : a;
      issue(we, f3, a, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
